// File: rtl/clock_pkg.sv
// Shared encodings for the millennium clock: display pages, blank code,
// scan slot indices and the editable-field enum used by the mode controller.
package clock_pkg;

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_e;

  typedef enum logic [1:0] {
    SEC_YEAR  = 2'd0,
    MIN_MONTH = 2'd1,
    HOUR_DAY  = 2'd2
  } field_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Time page slots (6 and 7 are unused on this page)
  localparam logic [2:0] SLOT_SEC_ONES  = 3'd0;
  localparam logic [2:0] SLOT_SEC_TENS  = 3'd1;
  localparam logic [2:0] SLOT_MIN_ONES  = 3'd2;
  localparam logic [2:0] SLOT_MIN_TENS  = 3'd3;
  localparam logic [2:0] SLOT_HOUR_ONES = 3'd4;
  localparam logic [2:0] SLOT_HOUR_TENS = 3'd5;

  // Date page slots
  localparam logic [2:0] SLOT_YEAR_ONES  = 3'd0;
  localparam logic [2:0] SLOT_YEAR_TENS  = 3'd1;
  localparam logic [2:0] SLOT_YEAR_HUNDS = 3'd2;
  localparam logic [2:0] SLOT_YEAR_THOUS = 3'd3;
  localparam logic [2:0] SLOT_MONTH_ONES = 3'd4;
  localparam logic [2:0] SLOT_MONTH_TENS = 3'd5;
  localparam logic [2:0] SLOT_DAY_ONES   = 3'd6;
  localparam logic [2:0] SLOT_DAY_TENS   = 3'd7;

  localparam logic [2:0] SLOT_LAST = 3'd7;

  // Everything the display needs for one frame, captured at the frame boundary
  typedef struct packed {
    page_e       page;
    logic        blink_second_year;
    logic        blink_minute_month;
    logic        blink_hour_day;
    logic [7:0]  sec;
    logic [7:0]  min;
    logic [7:0]  hour;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
  } snap_t;

endpackage

// File: rtl/scan_timebase.sv
// Scan timebase: digit prescaler, slot counter, frame tick, frame counter and
// blink phase. Exposes next-state values so the top can register outputs in step.
module scan_timebase
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 16,
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PW-1:0] presc_nxt,
  output logic [2:0]    slot_nxt,
  output logic          blink_phase_nxt,
  output logic          frame_tick
);

  logic [PW-1:0] presc_q;
  logic [2:0]    slot_q;
  logic [FW-1:0] frame_cnt_q;
  logic [FW-1:0] frame_cnt_nxt;
  logic          blink_phase_q;
  logic          tick;

  always_comb begin
    tick            = (presc_q == PW'(SCAN_DIV - 1));
    presc_nxt       = tick ? '0 : presc_q + 1'b1;
    slot_nxt        = tick ? slot_q + 3'd1 : slot_q;
    frame_tick      = tick && (slot_q == SLOT_LAST);
    frame_cnt_nxt   = frame_cnt_q;
    blink_phase_nxt = blink_phase_q;
    // Blink phase flips each time BLINK_DIV whole frames have been shown
    if (frame_tick) begin
      if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
        frame_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase_q;
      end else begin
        frame_cnt_nxt = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      slot_q        <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      presc_q       <= presc_nxt;
      slot_q        <= slot_nxt;
      frame_cnt_q   <= frame_cnt_nxt;
      blink_phase_q <= blink_phase_nxt;
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Eight-digit scan scheduler: snapshots page/BCD/blink inputs once per frame and
// drives one registered digit enable plus its BCD nibble per slot.
module display_scan_scheduler
  import clock_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 1,
  parameter int BLINK_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        show_date,
  input  logic        blink_second_year,
  input  logic        blink_minute_month,
  input  logic        blink_hour_day,
  input  logic [7:0]  sec_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  day_bcd,
  input  logic [7:0]  month_bcd,
  input  logic [15:0] year_bcd,
  output logic [7:0]  digit_en,
  output logic [3:0]  seg_bcd,
  output logic        blank,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] DEAD_P = PW'(DEAD_CYCLES);

  logic [PW-1:0] presc_nxt;
  logic [2:0]    slot_nxt;
  logic          blink_phase_nxt;
  logic          frame_tick;

  scan_timebase #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk             (clk),
    .rst_n           (rst_n),
    .presc_nxt       (presc_nxt),
    .slot_nxt        (slot_nxt),
    .blink_phase_nxt (blink_phase_nxt),
    .frame_tick      (frame_tick)
  );

  snap_t  snap_q;
  snap_t  snap_live;
  snap_t  snap_d;
  logic   slot_used;
  field_e slot_field;
  logic   field_blink;
  logic   slot_dark;
  logic [3:0] slot_nib;

  always_comb begin
    snap_live.page               = page_e'(show_date);
    snap_live.blink_second_year  = blink_second_year;
    snap_live.blink_minute_month = blink_minute_month;
    snap_live.blink_hour_day     = blink_hour_day;
    snap_live.sec                = sec_bcd;
    snap_live.min                = min_bcd;
    snap_live.hour               = hour_bcd;
    snap_live.day                = day_bcd;
    snap_live.month              = month_bcd;
    snap_live.year               = year_bcd;
    // The first slot of a new frame already shows the freshly latched inputs
    snap_d = frame_tick ? snap_live : snap_q;
  end

  always_comb begin
    slot_used  = 1'b1;
    slot_field = SEC_YEAR;
    slot_nib   = BLANK_CODE;
    if (snap_d.page == PAGE_TIME) begin
      case (slot_nxt)
        SLOT_SEC_ONES:  begin slot_nib = snap_d.sec[3:0];  slot_field = SEC_YEAR;  end
        SLOT_SEC_TENS:  begin slot_nib = snap_d.sec[7:4];  slot_field = SEC_YEAR;  end
        SLOT_MIN_ONES:  begin slot_nib = snap_d.min[3:0];  slot_field = MIN_MONTH; end
        SLOT_MIN_TENS:  begin slot_nib = snap_d.min[7:4];  slot_field = MIN_MONTH; end
        SLOT_HOUR_ONES: begin slot_nib = snap_d.hour[3:0]; slot_field = HOUR_DAY;  end
        SLOT_HOUR_TENS: begin slot_nib = snap_d.hour[7:4]; slot_field = HOUR_DAY;  end
        default:        slot_used = 1'b0;
      endcase
    end else begin
      case (slot_nxt)
        SLOT_YEAR_ONES:  begin slot_nib = snap_d.year[3:0];   slot_field = SEC_YEAR;  end
        SLOT_YEAR_TENS:  begin slot_nib = snap_d.year[7:4];   slot_field = SEC_YEAR;  end
        SLOT_YEAR_HUNDS: begin slot_nib = snap_d.year[11:8];  slot_field = SEC_YEAR;  end
        SLOT_YEAR_THOUS: begin slot_nib = snap_d.year[15:12]; slot_field = SEC_YEAR;  end
        SLOT_MONTH_ONES: begin slot_nib = snap_d.month[3:0];  slot_field = MIN_MONTH; end
        SLOT_MONTH_TENS: begin slot_nib = snap_d.month[7:4];  slot_field = MIN_MONTH; end
        SLOT_DAY_ONES:   begin slot_nib = snap_d.day[3:0];    slot_field = HOUR_DAY;  end
        default:         begin slot_nib = snap_d.day[7:4];    slot_field = HOUR_DAY;  end
      endcase
    end
  end

  always_comb begin
    field_blink = 1'b0;
    case (slot_field)
      SEC_YEAR:  field_blink = snap_d.blink_second_year;
      MIN_MONTH: field_blink = snap_d.blink_minute_month;
      HOUR_DAY:  field_blink = snap_d.blink_hour_day;
      default:   field_blink = 1'b0;
    endcase
    slot_dark = (presc_nxt < DEAD_P) || !slot_used || (blink_phase_nxt && field_blink);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= '0;
      digit_en    <= 8'h00;
      seg_bcd     <= BLANK_CODE;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      frame_start <= frame_tick;
      if (slot_dark) begin
        digit_en <= 8'h00;
        seg_bcd  <= BLANK_CODE;
        blank    <= 1'b1;
      end else begin
        digit_en <= 8'b1 << slot_nxt;
        seg_bcd  <= slot_nib;
        blank    <= 1'b0;
      end
    end
  end

endmodule
